dcache_wbuf: RTL and testbench
==============================

Name: dcache_wbuf

Overview:
- Write-back buffer between the data cache and the block-wide data memory.
- Accepts dirty-block evictions from the cache and queues them in a small FIFO.
- Drains them to memory in the background.
- Serves cache read-miss fills, forwarding from the buffer when the missed block is still queued, so evictions never stall a refill unless the buffer is full.

Parameters:
- ADDR_W, 32, byte address width; block-aligned addresses have bits [6:0] = 0.
- BLOCK_W, 1024, cache block width in bits (128 bytes).
- DEPTH, 4, buffer entries (power of two, >= 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- evict_valid  in  1  cache presents a dirty block.
- evict_ready  out  1  buffer can accept; transfer occurs when valid && ready.
- evict_addr  in  ADDR_W  block address of the eviction.
- evict_data  in  BLOCK_W  block contents of the eviction.
- miss_req  in  1  cache requests a block fill; held until miss_ack.
- miss_addr  in  ADDR_W  block address of the fill request.
- miss_ack  out  1  one-cycle pulse; miss_data is valid in the same cycle.
- miss_data  out  BLOCK_W  fill data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = block write, 0 = block read.
- mem_addr  out  ADDR_W  memory block address.
- mem_wdata  out  BLOCK_W  write data.
- mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid with it on reads.
- mem_rdata  in  BLOCK_W  read data from memory.
- flush  in  1  level; request a full drain.
- flush_done  out  1  one-cycle pulse when the drain completes.
- count  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: all entries invalid; head/tail/count = 0; state IDLE. Outputs reset as follows:
  - evict_ready=1, miss_ack=0, miss_data=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - flush_done=0.
- Reset asserted mid-transaction abandons the transaction. An mem_ack arriving after reset is ignored while in IDLE.
- evict_ready = (count < DEPTH).
- Coalescing: an eviction whose address matches a valid non-head entry, or a head entry not currently being written, overwrites that entry's data. count is unchanged.
- If the matching entry is the head while WR is in flight, the eviction allocates a new tail entry.
- Lookup compares miss_addr against all valid entries. If several match, the youngest wins.
- State IDLE, evaluated in this priority order:
  - miss_req && lookup hit -> FWD.
  - miss_req && count < DEPTH -> RD.
  - count > 0 -> WR.
  - Otherwise stay in IDLE.
- FWD: next cycle, miss_ack=1 and miss_data = the matching entry's data. No memory access. Return to IDLE.
- RD: drive mem_req=1, mem_we=0, mem_addr=miss_addr.
  - On mem_ack: miss_ack=1 and miss_data=mem_rdata in the same cycle; mem_req drops; return to IDLE.
  - Latency is 1 cycle plus the memory latency.
- WR: drive mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry.
  - On mem_ack: invalidate head, head++ (wraps modulo DEPTH), count--, return to IDLE.
- A miss with a full buffer drains exactly one entry (WR), then re-arbitrates.
- Simultaneous evict accept and WR completion in one cycle: count is unchanged.
- The FWD lookup uses entry contents at the cycle miss_req is sampled. An eviction to the same address in that cycle is visible to later lookups only.
- Flush: while flush=1, WR has priority over RD/FWD; evictions are still accepted.
  - flush_done pulses one cycle when count==0 and state==IDLE, then not again until flush deasserts and reasserts.
  - flush with count==0 gives flush_done on the next edge.
- Pointers wrap; full and empty are distinguished by count, not by pointer equality.

Decomposition:
- Shared package / define file: ADDR_W, BLOCK_W, CACHE_OFFSET_LEN=7, state encodings (IDLE, FWD, RD, WR).
- One sub-module, wbuf_cam: entry storage plus parallel address compare. Outputs hit, youngest matching index, and head data.
- The FSM and arbitration stay in the top level.

Test Plan:
- Reset mid-WR (mem_req=1) -> mem_req=0, count=0, evict_ready=1 the same instant. A late mem_ack causes no state change.
- Evict 0x400 (data A), then 0x800 (data B), memory latency 3 -> two writes in FIFO order: 0x400/A first, then 0x800/B; count goes 2->1->0.
- Evict 0x1000 (data C), then immediately miss_req 0x1000 -> miss_ack 1 cycle later with C. No mem read issued; entry still queued.
- Fill 4 entries (0x0, 0x80, 0x100, 0x180), then miss_req 0x200 -> evict_ready=0; one WR to 0x0; then RD 0x200; miss_ack with mem_rdata.
- Evict 0x80 (X), then 0x80 (Y) while the head is elsewhere -> count=1 for 0x80; the single memory write carries Y.
- Queue 3 entries and assert flush -> 3 writes back to back, then one flush_done pulse with count=0. Holding flush gives no second pulse.

Source files
------------

// File: rtl/dcache_wbuf_pkg.sv
// rtl/dcache_wbuf_pkg.sv - shared constants and FSM encoding for the data-cache write-back buffer
package dcache_wbuf_pkg;

  // Default geometry: 32-bit byte addresses, 128-byte blocks, four buffer entries
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned BLOCK_W          = 1024;
  localparam int unsigned DEPTH            = 4;
  localparam int unsigned CACHE_OFFSET_LEN = 7;

  // Controller states: idle arbitration, buffer forward, memory fill read, drain write
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/dcache_wbuf_cam.sv
// rtl/dcache_wbuf_cam.sv - write-back buffer entry storage with parallel block-address compare
module wbuf_cam #(
  parameter int unsigned ADDR_W  = dcache_wbuf_pkg::ADDR_W,
  parameter int unsigned BLOCK_W = dcache_wbuf_pkg::BLOCK_W,
  parameter int unsigned DEPTH   = dcache_wbuf_pkg::DEPTH
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic                                              wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]                          wr_idx_i,
  input  logic [ADDR_W-1:0]                                 wr_addr_i,
  input  logic [BLOCK_W-1:0]                                wr_data_i,
  input  logic                                              inv_en_i,
  input  logic [$clog2(DEPTH)-1:0]                          inv_idx_i,
  input  logic [$clog2(DEPTH)-1:0]                          head_idx_i,
  input  logic [ADDR_W-dcache_wbuf_pkg::CACHE_OFFSET_LEN-1:0] miss_tag_i,
  input  logic [ADDR_W-dcache_wbuf_pkg::CACHE_OFFSET_LEN-1:0] evict_tag_i,
  output logic                                              miss_hit_o,
  output logic [BLOCK_W-1:0]                                miss_data_o,
  output logic                                              evict_hit_o,
  output logic [$clog2(DEPTH)-1:0]                          evict_idx_o,
  output logic [ADDR_W-1:0]                                 head_addr_o,
  output logic [BLOCK_W-1:0]                                head_data_o
);
  import dcache_wbuf_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]   valid_q;
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [BLOCK_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   miss_idx;

  // Valid bits: drained head is cleared, written slot is set (never the same slot in one cycle)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (inv_en_i) valid_q[inv_idx_i] <= 1'b0;
      if (wr_en_i)  valid_q[wr_idx_i]  <= 1'b1;
    end
  end

  // Payload storage: allocation and coalescing share the one write port
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      addr_q[wr_idx_i] <= wr_addr_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Scan oldest to youngest from the head so the last match found is the youngest
  always_comb begin
    scan_idx    = '0;
    miss_hit_o  = 1'b0;
    miss_idx    = '0;
    evict_hit_o = 1'b0;
    evict_idx_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx_i + PTR_W'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx][ADDR_W-1:CACHE_OFFSET_LEN] == miss_tag_i)) begin
        miss_hit_o = 1'b1;
        miss_idx   = scan_idx;
      end
      if (valid_q[scan_idx] && (addr_q[scan_idx][ADDR_W-1:CACHE_OFFSET_LEN] == evict_tag_i)) begin
        evict_hit_o = 1'b1;
        evict_idx_o = scan_idx;
      end
    end
  end

  assign miss_data_o = data_q[miss_idx];
  assign head_addr_o = addr_q[head_idx_i];
  assign head_data_o = data_q[head_idx_i];

endmodule

// File: rtl/dcache_wbuf.sv
// rtl/dcache_wbuf.sv - data-cache write-back buffer with miss forwarding and background drain
module dcache_wbuf #(
  parameter int unsigned ADDR_W  = dcache_wbuf_pkg::ADDR_W,
  parameter int unsigned BLOCK_W = dcache_wbuf_pkg::BLOCK_W,
  parameter int unsigned DEPTH   = dcache_wbuf_pkg::DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     evict_valid_i,
  output logic                     evict_ready_o,
  input  logic [ADDR_W-1:0]        evict_addr_i,
  input  logic [BLOCK_W-1:0]       evict_data_i,
  input  logic                     miss_req_i,
  input  logic [ADDR_W-1:0]        miss_addr_i,
  output logic                     miss_ack_o,
  output logic [BLOCK_W-1:0]       miss_data_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [BLOCK_W-1:0]       mem_wdata_o,
  input  logic                     mem_ack_i,
  input  logic [BLOCK_W-1:0]       mem_rdata_i,
  input  logic                     flush_i,
  output logic                     flush_done_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import dcache_wbuf_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_state_e          state_q;
  wb_state_e          idle_next;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               fwd_ack_q;
  logic [BLOCK_W-1:0] fwd_data_q;
  logic               flush_done_q;
  logic               flush_seen_q;

  logic               not_full;
  logic               evict_fire;
  logic               coalesce;
  logic               alloc;
  logic               wr_done;
  logic               rd_done;
  logic               miss_hit;
  logic [BLOCK_W-1:0] miss_hit_data;
  logic               evict_hit;
  logic [PTR_W-1:0]   evict_idx;
  logic [ADDR_W-1:0]  head_addr;
  logic [BLOCK_W-1:0] head_data;

  assign not_full   = (count_q < CNT_W'(DEPTH));
  assign evict_fire = evict_valid_i && not_full;
  assign wr_done    = (state_q == ST_WR) && mem_ack_i;
  assign rd_done    = (state_q == ST_RD) && mem_ack_i;
  // The head is frozen while its write is on the bus; a same-address eviction then needs a fresh slot
  assign coalesce   = evict_fire && evict_hit && !((state_q == ST_WR) && (evict_idx == head_q));
  assign alloc      = evict_fire && !coalesce;

  wbuf_cam #(
    .ADDR_W  (ADDR_W),
    .BLOCK_W (BLOCK_W),
    .DEPTH   (DEPTH)
  ) u_cam (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_en_i     (evict_fire),
    .wr_idx_i    (coalesce ? evict_idx : tail_q),
    .wr_addr_i   (evict_addr_i),
    .wr_data_i   (evict_data_i),
    .inv_en_i    (wr_done),
    .inv_idx_i   (head_q),
    .head_idx_i  (head_q),
    .miss_tag_i  (miss_addr_i[ADDR_W-1:CACHE_OFFSET_LEN]),
    .evict_tag_i (evict_addr_i[ADDR_W-1:CACHE_OFFSET_LEN]),
    .miss_hit_o  (miss_hit),
    .miss_data_o (miss_hit_data),
    .evict_hit_o (evict_hit),
    .evict_idx_o (evict_idx),
    .head_addr_o (head_addr),
    .head_data_o (head_data)
  );

  // Pointer and occupancy update; an accept and a drain in the same cycle cancel in count
  always_comb begin
    head_d  = wr_done ? head_q + 1'b1 : head_q;
    tail_d  = alloc ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CNT_W'(alloc) - CNT_W'(wr_done);
  end

  // Idle arbitration: flush forces draining first, otherwise forward, fill, then background drain
  always_comb begin
    idle_next = ST_IDLE;
    if (flush_i && (count_q != '0)) begin
      idle_next = ST_WR;
    end else if (miss_req_i && miss_hit) begin
      idle_next = ST_FWD;
    end else if (miss_req_i && not_full) begin
      idle_next = ST_RD;
    end else if (count_q != '0) begin
      idle_next = ST_WR;
    end
  end

  // Main controller with registered request and forward outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      fwd_ack_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      fwd_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q <= idle_next;
          case (idle_next)
            ST_FWD: begin
              fwd_ack_q  <= 1'b1;
              fwd_data_q <= miss_hit_data;
            end
            ST_RD: begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= miss_addr_i;
            end
            ST_WR: begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b1;
              mem_addr_q <= head_addr;
            end
            default: begin
            end
          endcase
        end
        ST_FWD: begin
          state_q <= ST_IDLE;
        end
        ST_RD, ST_WR: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // One flush_done pulse per flush assertion, once the buffer is empty and idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_done_q <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (!flush_i) begin
        flush_seen_q <= 1'b0;
      end else if (!flush_seen_q && (count_q == '0) && (state_q == ST_IDLE)) begin
        flush_done_q <= 1'b1;
        flush_seen_q <= 1'b1;
      end
    end
  end

  assign evict_ready_o = not_full;
  assign miss_ack_o    = fwd_ack_q || rd_done;
  assign miss_data_o   = rd_done ? mem_rdata_i : fwd_data_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = (state_q == ST_WR) ? head_data : '0;
  assign flush_done_o  = flush_done_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_dcache_wbuf.sv
// tb/tb_dcache_wbuf.sv - directed self-checking bench for dcache_wbuf
module tb_dcache_wbuf;

  localparam int BW = 1024;

  localparam logic [BW-1:0] D_A = {16{64'hAAAA_1111_0000_0401}};
  localparam logic [BW-1:0] D_B = {16{64'hBBBB_2222_0000_0802}};
  localparam logic [BW-1:0] D_C = {16{64'hCCCC_3333_0000_1003}};
  localparam logic [BW-1:0] D_X = {16{64'h1234_5678_0000_0080}};
  localparam logic [BW-1:0] D_Y = {16{64'h8765_4321_0000_0081}};
  localparam logic [BW-1:0] D_Z = {16{64'h0F0F_F0F0_0000_2000}};
  localparam logic [BW-1:0] D_P = {16{64'h5555_AAAA_0000_3000}};
  localparam logic [BW-1:0] D_Q = {16{64'h6666_9999_0000_3001}};

  logic          clk, rst_n;
  logic          evict_valid, evict_ready;
  logic [31:0]   evict_addr;
  logic [BW-1:0] evict_data;
  logic          miss_req, miss_ack;
  logic [31:0]   miss_addr;
  logic [BW-1:0] miss_data;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          flush, flush_done;
  logic [2:0]    count;

  int n_checks, n_errors;
  bit mem_auto;
  int mem_lat;
  bit            op_we[$];
  logic [31:0]   op_addr[$];
  logic [BW-1:0] op_data[$];
  int miss_ack_cnt, fd_cnt;
  bit hist_en;
  logic [2:0] hist[$];
  logic [2:0] prev_cnt;

  dcache_wbuf dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .evict_valid_i (evict_valid),
    .evict_ready_o (evict_ready),
    .evict_addr_i  (evict_addr),
    .evict_data_i  (evict_data),
    .miss_req_i    (miss_req),
    .miss_addr_i   (miss_addr),
    .miss_ack_o    (miss_ack),
    .miss_data_o   (miss_data),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .flush_i       (flush),
    .flush_done_o  (flush_done),
    .count_o       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BW-1:0] pat(input logic [31:0] a);
    return {32{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    logic [63:0] g, e;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      g = got[63:0];
      e = exp[63:0];
      $display("FAIL %s: got 0x%0h expected 0x%0h (low 64 bits)", tag, g, e);
    end
  endtask

  // Memory model: acknowledges a held request mem_lat cycles after first seeing it
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_auto && mem_req && rst_n) begin
        repeat (mem_lat - 1) begin @(posedge clk); #1; end
        op_we.push_back(mem_we);
        op_addr.push_back(mem_addr);
        if (mem_we) begin
          op_data.push_back(mem_wdata);
        end else begin
          mem_rdata = pat(mem_addr);
          op_data.push_back('0);
        end
        mem_ack = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (miss_ack === 1'b1) miss_ack_cnt++;
    if (flush_done === 1'b1) fd_cnt++;
    if (count !== prev_cnt && hist_en) hist.push_back(count);
    prev_cnt = count;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    op_we.delete();
    op_addr.delete();
    op_data.delete();
  endtask

  task automatic do_evict(input logic [31:0] a, input logic [BW-1:0] d);
    int n;
    n = 0;
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    @(negedge clk);
    while (!evict_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!evict_ready) check("evict_timeout", evict_ready, 1'b1);
    @(posedge clk); #1;
    evict_valid = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] a, output logic [BW-1:0] d, output int lat,
                         output logic [2:0] cnt);
    miss_req  = 1'b1;
    miss_addr = a;
    lat = 0;
    d   = '0;
    cnt = '0;
    forever begin
      @(negedge clk);
      if (miss_ack) begin
        d   = miss_data;
        cnt = count;
        break;
      end
      lat++;
      if (lat > 200) begin
        check("miss_ack_timeout", miss_ack, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    miss_req = 1'b0;
  endtask

  task automatic wait_mem_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) check("mem_req_timeout", mem_req, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((count != 3'd0 || mem_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (count != 3'd0) check("drain_timeout", count, 3'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [BW-1:0] d;
    int lat, n, acks_before;
    logic [2:0] c;

    n_checks = 0; n_errors = 0;
    mem_auto = 1'b0; mem_lat = 3;
    miss_ack_cnt = 0; fd_cnt = 0; hist_en = 1'b0;
    rst_n = 1'b0; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    miss_req = 1'b0; miss_addr = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values
    check("rst_evict_ready", evict_ready, 1'b1);
    check("rst_miss_ack", miss_ack, 1'b0);
    check("rst_miss_data", miss_data, '0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_count", count, 3'd0);

    // Reset in the middle of a write, then a stale acknowledge
    do_evict(32'h400, D_A);
    wait_mem_req();
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 32'h400);
    check("wr_mem_wdata", mem_wdata, D_A);
    check("wr_count", count, 3'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_count", count, 3'd0);
    check("midrst_evict_ready", evict_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    acks_before = miss_ack_cnt;
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("late_ack_mem_req", mem_req, 1'b0);
    check("late_ack_count", count, 3'd0);
    check("late_ack_miss_ack", miss_ack_cnt, acks_before);
    @(posedge clk); #1;

    // Two evictions drain in FIFO order
    mem_auto = 1'b1; mem_lat = 3;
    clear_log();
    hist.delete();
    hist_en = 1'b1;
    do_evict(32'h400, D_A);
    do_evict(32'h800, D_B);
    wait_drain();
    hist_en = 1'b0;
    check("fifo_hist_len", hist.size(), 4);
    check("fifo_hist0", hist[0], 3'd1);
    check("fifo_hist1", hist[1], 3'd2);
    check("fifo_hist2", hist[2], 3'd1);
    check("fifo_hist3", hist[3], 3'd0);
    check("fifo_nops", op_we.size(), 2);
    check("fifo_op0_addr", op_addr[0], 32'h400);
    check("fifo_op0_data", op_data[0], D_A);
    check("fifo_op1_addr", op_addr[1], 32'h800);
    check("fifo_op1_data", op_data[1], D_B);

    // Miss hits a queued eviction: forwarded next cycle, no memory read
    clear_log();
    do_evict(32'h1000, D_C);
    do_miss(32'h1000, d, lat, c);
    check("fwd_latency", lat, 1);
    check("fwd_data", d, D_C);
    check("fwd_count", c, 3'd1);
    wait_drain();
    check("fwd_nops", op_we.size(), 1);
    check("fwd_op0_we", op_we[0], 1'b1);
    check("fwd_op0_addr", op_addr[0], 32'h1000);
    check("fwd_op0_data", op_data[0], D_C);

    // Full buffer plus a missing block: one drain, then the fill read
    mem_auto = 1'b0;
    clear_log();
    do_evict(32'h0, D_A);
    do_evict(32'h80, D_B);
    do_evict(32'h100, D_C);
    do_evict(32'h180, D_X);
    @(negedge clk);
    check("full_evict_ready", evict_ready, 1'b0);
    check("full_count", count, 3'd4);
    @(posedge clk); #1;
    mem_lat = 2;
    mem_auto = 1'b1;
    do_miss(32'h200, d, lat, c);
    check("fill_data", d, pat(32'h200));
    check("fill_count", c, 3'd3);
    wait_drain();
    check("fill_nops", op_we.size(), 5);
    check("fill_op0_we", op_we[0], 1'b1);
    check("fill_op0_addr", op_addr[0], 32'h0);
    check("fill_op1_we", op_we[1], 1'b0);
    check("fill_op1_addr", op_addr[1], 32'h200);
    check("fill_op2_addr", op_addr[2], 32'h80);
    check("fill_op4_addr", op_addr[4], 32'h180);
    check("fill_op4_data", op_data[4], D_X);

    // Coalescing into a non-head entry keeps one slot with the newest data
    mem_auto = 1'b0;
    clear_log();
    do_evict(32'h2000, D_Z);
    wait_mem_req();
    do_evict(32'h80, D_X);
    do_evict(32'h80, D_Y);
    check("coal_count", count, 3'd2);
    mem_auto = 1'b1;
    wait_drain();
    check("coal_nops", op_we.size(), 2);
    check("coal_op0_addr", op_addr[0], 32'h2000);
    check("coal_op0_data", op_data[0], D_Z);
    check("coal_op1_addr", op_addr[1], 32'h80);
    check("coal_op1_data", op_data[1], D_Y);

    // Same address as the head being written allocates a new entry
    mem_auto = 1'b0;
    clear_log();
    do_evict(32'h3000, D_P);
    wait_mem_req();
    do_evict(32'h3000, D_Q);
    check("inflight_count", count, 3'd2);
    mem_auto = 1'b1;
    wait_drain();
    check("inflight_nops", op_we.size(), 2);
    check("inflight_op0_data", op_data[0], D_P);
    check("inflight_op1_addr", op_addr[1], 32'h3000);
    check("inflight_op1_data", op_data[1], D_Q);

    // Flush drains everything, pulses once, and pulses again only after re-assertion
    mem_auto = 1'b0;
    clear_log();
    do_evict(32'h4000, D_A);
    do_evict(32'h4080, D_B);
    do_evict(32'h4100, D_C);
    fd_cnt = 0;
    mem_lat = 2;
    mem_auto = 1'b1;
    flush = 1'b1;
    n = 0;
    while (fd_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("flush_pulse_seen", fd_cnt, 1);
    check("flush_count", count, 3'd0);
    check("flush_nops", op_we.size(), 3);
    check("flush_op0_addr", op_addr[0], 32'h4000);
    check("flush_op1_addr", op_addr[1], 32'h4080);
    check("flush_op2_addr", op_addr[2], 32'h4100);
    repeat (10) @(negedge clk);
    check("flush_single_pulse", fd_cnt, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_empty_pulse", flush_done, 1'b1);
    @(posedge clk); #1;
    check("flush_empty_pulse_end", flush_done, 1'b0);
    flush = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
